// File: rtl/alu_cmd_master_if.sv
// Command, slave-bus and response signals of alu_cmd_master.
// The master modport is the block itself; the slave modport is its environment.
interface alu_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_op1;
    logic [31:0] cmd_op2;
    logic [3:0]  cmd_opcode;

    logic        M_sel;
    logic        M_wr;
    logic [7:0]  M_addr;
    logic [31:0] M_dout;
    logic [31:0] M_din;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result1;
    logic [31:0] rsp_result2;
    logic        rsp_timeout;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_op1, cmd_op2, cmd_opcode, M_din, rsp_ready,
        output cmd_ready, M_sel, M_wr, M_addr, M_dout,
               rsp_valid, rsp_result1, rsp_result2, rsp_timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_op1, cmd_op2, cmd_opcode, M_din, rsp_ready,
        input  cmd_ready, M_sel, M_wr, M_addr, M_dout,
               rsp_valid, rsp_result1, rsp_result2, rsp_timeout, busy
    );
endinterface

// File: rtl/alu_cmd_master.sv
// Bus master that sequences one ALU_w_mul register-slave operation per accepted
// command (write operands/opcode, start, poll done, read results, clear) and responds.
module alu_cmd_master #(
    parameter int         MAX_POLLS = 256,
    parameter logic [7:0] A_OP1     = 8'h00,
    parameter logic [7:0] A_OP2     = 8'h01,
    parameter logic [7:0] A_OPC     = 8'h02,
    parameter logic [7:0] A_R1      = 8'h03,
    parameter logic [7:0] A_R2      = 8'h04,
    parameter logic [7:0] A_START   = 8'h05,
    parameter logic [7:0] A_DONE    = 8'h06,
    parameter logic [7:0] A_CLR     = 8'h07
) (
    input  logic             clk,
    input  logic             reset,
    alu_cmd_master_if.master bus
);

    localparam int CW = $clog2(MAX_POLLS) + 1;
    localparam logic [CW-1:0] LAST_POLL = CW'(MAX_POLLS - 1);

    typedef enum logic [3:0] {
        IDLE, WR_OP1, WR_OP2, WR_OPC, WR_START, POLL_RQ, POLL_CK,
        RD1_RQ, RD1_CK, RD2_RQ, RD2_CK, WR_CLR, RSP
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    logic [3:0]    opc_q, opc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   dout_q, dout_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   res1_q, res1_d;
    logic [31:0]   res2_q, res2_d;
    logic          tout_q, tout_d;
    logic          busy_q, busy_d;

    assign bus.cmd_ready   = (state_q == IDLE) && !reset;
    assign bus.M_sel       = sel_q;
    assign bus.M_wr        = wr_q;
    assign bus.M_addr      = addr_q;
    assign bus.M_dout      = dout_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result1 = res1_q;
    assign bus.rsp_result2 = res2_q;
    assign bus.rsp_timeout = tout_q;
    assign bus.busy        = busy_q;

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        opc_d       = opc_q;
        cnt_d       = cnt_q;
        res1_d      = res1_q;
        res2_d      = res2_q;
        tout_d      = tout_q;
        sel_d       = 1'b0;
        wr_d        = 1'b0;
        addr_d      = 8'h00;
        dout_d      = 32'h0;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op1_d   = bus.cmd_op1;
                    op2_d   = bus.cmd_op2;
                    opc_d   = bus.cmd_opcode;
                    tout_d  = 1'b0;
                    state_d = WR_OP1;
                end
            end
            WR_OP1:   state_d = WR_OP2;
            WR_OP2:   state_d = WR_OPC;
            WR_OPC:   state_d = WR_START;
            WR_START: begin
                cnt_d   = '0;
                state_d = POLL_RQ;
            end
            POLL_RQ:  state_d = POLL_CK;
            // Read data for the request issued last cycle is only valid here.
            POLL_CK: begin
                if (bus.M_din[0]) begin
                    state_d = RD1_RQ;
                end else if (cnt_q == LAST_POLL) begin
                    tout_d  = 1'b1;
                    res1_d  = 32'h0;
                    res2_d  = 32'h0;
                    state_d = WR_CLR;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = POLL_RQ;
                end
            end
            RD1_RQ:   state_d = RD1_CK;
            RD1_CK: begin
                res1_d  = bus.M_din;
                state_d = RD2_RQ;
            end
            RD2_RQ:   state_d = RD2_CK;
            RD2_CK: begin
                res2_d  = bus.M_din;
                state_d = WR_CLR;
            end
            WR_CLR:   state_d = RSP;
            RSP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        // Bus outputs are decoded from the next state so they register in step with it.
        case (state_d)
            WR_OP1:   begin sel_d = 1'b1; wr_d = 1'b1; addr_d = A_OP1;   dout_d = op1_d; end
            WR_OP2:   begin sel_d = 1'b1; wr_d = 1'b1; addr_d = A_OP2;   dout_d = op2_d; end
            WR_OPC:   begin sel_d = 1'b1; wr_d = 1'b1; addr_d = A_OPC;   dout_d = {28'h0, opc_d}; end
            WR_START: begin sel_d = 1'b1; wr_d = 1'b1; addr_d = A_START; dout_d = 32'h1; end
            POLL_RQ:  begin sel_d = 1'b1; addr_d = A_DONE; end
            RD1_RQ:   begin sel_d = 1'b1; addr_d = A_R1; end
            RD2_RQ:   begin sel_d = 1'b1; addr_d = A_R2; end
            WR_CLR:   begin sel_d = 1'b1; wr_d = 1'b1; addr_d = A_CLR;   dout_d = 32'h1; end
            RSP:      rsp_valid_d = 1'b1;
            default:  ;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op1_q       <= 32'h0;
            op2_q       <= 32'h0;
            opc_q       <= 4'h0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 8'h00;
            dout_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            res1_q      <= 32'h0;
            res2_q      <= 32'h0;
            tout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            opc_q       <= opc_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            rsp_valid_q <= rsp_valid_d;
            res1_q      <= res1_d;
            res2_q      <= res2_d;
            tout_q      <= tout_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Upstream bus master for the ALU_w_mul register slave.
- Accepts ALU commands (operand1, operand2, opcode) over a valid/ready stream.
- Runs the slave register protocol: write operands and opcode, start, poll op_done, read result1/result2, clear.
- Returns both results on a valid/ready response stream, so software/testbench no longer sequences the slave manually.

Parameters:
- MAX_POLLS, 256, number of op_done polls before the command is abandoned with rsp_timeout=1.
- A_OP1, 8'h00, operand1 register address.
- A_OP2, 8'h01, operand2 register address.
- A_OPC, 8'h02, opcode register address.
- A_R1, 8'h03, result1 register address.
- A_R2, 8'h04, result2 register address.
- A_START, 8'h05, start register address.
- A_DONE, 8'h06, op_done register address.
- A_CLR, 8'h07, clear register address.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op1  in  32  operand1.
- cmd_op2  in  32  operand2.
- cmd_opcode  in  4  ALU opcode (e.g. 4'hB ADD, 4'hD MUL).
- M_sel  out  1  slave select.
- M_wr  out  1  1=write, 0=read.
- M_addr  out  8  slave register address.
- M_dout  out  32  write data to slave S_din.
- M_din  in  32  read data from slave S_dout.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result1  out  32  captured result1.
- rsp_result2  out  32  captured result2.
- rsp_timeout  out  1  op_done never seen within MAX_POLLS.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: M_sel=0, M_wr=0, M_addr=0, M_dout=0, rsp_valid=0, rsp_result1/2=0, rsp_timeout=0, busy=0, state=IDLE, poll counter=0.
- All bus and response outputs are registered.
- cmd_ready = (state==IDLE) and not reset; it is combinational from state.
- Handshake: command captured into internal registers on cmd_valid & cmd_ready; the cmd_* inputs are don't-care afterwards.
- Slave read timing: M_din is valid in the cycle after a read cycle (M_sel=1, M_wr=0). It is sampled only in the *_CK states.
- FSM, one bus cycle per state, M_sel=1 unless noted:
  - IDLE: bus idle. Go to WR_OP1 on accept.
  - WR_OP1: write op1 to A_OP1.
  - WR_OP2: write op2 to A_OP2.
  - WR_OPC: write {28'b0, opcode} to A_OPC.
  - WR_START: write 32'h1 to A_START; poll counter=0.
  - POLL_RQ: read A_DONE.
  - POLL_CK: M_sel=0; sample M_din.
    - If M_din[0]=1, go to RD1_RQ.
    - Else if counter==MAX_POLLS-1, set rsp_timeout=1 and results=0, go to WR_CLR.
    - Else increment counter and go to POLL_RQ.
  - RD1_RQ: read A_R1.
  - RD1_CK: M_sel=0; capture rsp_result1=M_din.
  - RD2_RQ: read A_R2.
  - RD2_CK: M_sel=0; capture rsp_result2=M_din.
  - WR_CLR: write 32'h1 to A_CLR.
  - RSP: bus idle, rsp_valid=1 with results and flag held stable. On rsp_ready, go to IDLE (rsp_valid=0 next cycle).
- In every non-bus cycle: M_sel=0, M_wr=0, M_addr=0, M_dout=0.
- Latency: with op_done seen on the first poll, rsp_valid rises 12 cycles after the accept edge. Each extra poll adds 2 cycles.
- A new command cannot be accepted in the same cycle as the response handshake. The earliest next accept is the cycle after (IDLE).
- rsp_ready asserted outside RSP is ignored.
- Timeout path still issues the clear write before responding.
- rsp_timeout is cleared when the next command is accepted.
- Reset mid-operation: the next edge forces all outputs to reset values. No clear write is issued, the in-flight command is dropped, and the response is lost.
- The counter has log2(MAX_POLLS)+1 bits; no wrap occurs because the counter exits at MAX_POLLS-1.

Test Plan:
- Reset held 2 cycles, then ADD (op1 0x0123_0123, op2 0x3210_3210, opcode 4'hB) against a slave model with 1-cycle done -> bus trace: W00=0x01230123, W01=0x32103210, W02=0xB, W05=1, R06, R03, R04, W07=1. Response rsp_result1=0x3333_3333, rsp_timeout=0, rsp_valid 12 cycles after accept.
- MUL (0x0001_2345 × 0x0006_7890, opcode 4'hD), model done after 20 cycles (low word in result1) -> repeated R06 polls every 2 cycles, then rsp_result1=0x5CCA_2ED0, rsp_result2=0x0000_0007.
- Model never sets op_done, MAX_POLLS=4 -> exactly 4 R06 reads, then W07=1, then rsp_valid with rsp_timeout=1 and results 0.
- rsp_ready held low 5 cycles in RSP -> rsp_valid and results stable. cmd_ready=0 throughout; back-to-back second command accepted the cycle after the handshake.
- reset asserted during POLL_RQ -> next cycle M_sel=0, busy=0, rsp_valid=0, cmd_ready=1. No W07 is issued.
